// File: rtl/icache_line_fill_pkg.sv
// Shared types and size derivations for the I-cache line-fill engine.
package icache_fill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_RDATA = 3'd2,
        ST_DONE  = 3'd3,
        ST_WAIT  = 3'd4
    } fill_state_e;

    function automatic int calc_off_bits(input int line_size);
        return $clog2(line_size / 32'sd8);
    endfunction

    function automatic int calc_beats(input int line_size, input int bus_width);
        return line_size / bus_width;
    endfunction

endpackage

// File: rtl/icache_line_fill_if.sv
// Miss-port and memory-bus signal bundle; master is the fill engine, slave is its environment.
interface icache_line_fill_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 256,
    parameter int BUS_WIDTH  = 32
) ();

    logic                  c_strobe_i;
    logic [ADDR_WIDTH-1:0] c_addr_i;
    logic                  c_ready_o;
    logic [LINE_SIZE-1:0]  c_data_o;
    logic                  bus_arvalid_o;
    logic [ADDR_WIDTH-1:0] bus_araddr_o;
    logic [7:0]            bus_arlen_o;
    logic                  bus_arready_i;
    logic                  bus_rvalid_i;
    logic [BUS_WIDTH-1:0]  bus_rdata_i;
    logic                  bus_rlast_i;
    logic                  bus_rready_o;
    logic                  fill_err_o;

    modport master (
        input  c_strobe_i, c_addr_i, bus_arready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
        output c_ready_o, c_data_o, bus_arvalid_o, bus_araddr_o, bus_arlen_o, bus_rready_o,
               fill_err_o
    );

    modport slave (
        output c_strobe_i, c_addr_i, bus_arready_i, bus_rvalid_i, bus_rdata_i, bus_rlast_i,
        input  c_ready_o, c_data_o, bus_arvalid_o, bus_araddr_o, bus_arlen_o, bus_rready_o,
               fill_err_o
    );

endinterface

// File: rtl/icache_line_fill_line_assembler.sv
// Beat register file for a cache-line fill; beat 0 lands in the most significant slot.
module line_assembler #(
    parameter int BUS_WIDTH = 32,
    parameter int BEATS     = 8,
    parameter int CNT_W     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we,
    input  logic [CNT_W-1:0]           idx,
    input  logic [BUS_WIDTH-1:0]       wdata,
    output logic [BEATS*BUS_WIDTH-1:0] line
);

    localparam int LINE_W = BEATS * BUS_WIDTH;

    logic [BUS_WIDTH-1:0] slot_r [BEATS];

    // Slot storage, written one beat at a time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < BEATS; k++) begin
                slot_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BEATS; k++) begin
                if (we && (idx == CNT_W'(k))) begin
                    slot_r[k] <= wdata;
                end
            end
        end
    end

    // MSB-first packing: lowest-address beat occupies the top of the line.
    always_comb begin
        line = '0;
        for (int k = 0; k < BEATS; k++) begin
            line[LINE_W-1-k*BUS_WIDTH -: BUS_WIDTH] = slot_r[k];
        end
    end

endmodule

// File: rtl/icache_line_fill.sv
// I-cache line-fill engine: one burst read per miss, assembled into a line.
// Optional last-line buffer enabled by defining ICACHE_LINE_FILL_LINEBUF_EN.
module icache_line_fill
    import icache_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_SIZE  = 256,
    parameter int BUS_WIDTH  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    icache_line_fill_if.master io
);

    localparam int OFF_BITS = calc_off_bits(LINE_SIZE);
    localparam int BEATS    = calc_beats(LINE_SIZE, BUS_WIDTH);
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [7:0]            ARLEN    = 8'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = {{(ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    fill_state_e           state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic                  err_r, err_s;
    logic                  arvalid_r, rready_r, c_ready_r;
    logic [7:0]            arlen_r;
    logic [ADDR_WIDTH-1:0] aligned_s;
    logic                  beat_we_s;
    logic [LINE_SIZE-1:0]  line_s;

    assign aligned_s = io.c_addr_i & OFF_MASK;
    assign beat_we_s = (state_r == ST_RDATA) && io.bus_rvalid_i;

`ifdef ICACHE_LINE_FILL_LINEBUF_EN
    logic                           buf_valid_r;
    logic [ADDR_WIDTH-OFF_BITS-1:0] buf_tag_r;
    logic                           hit_s;

    assign hit_s = buf_valid_r && (buf_tag_r == aligned_s[ADDR_WIDTH-1:OFF_BITS]);

    // Tag of the line held in the assembler; dropped as soon as a new burst starts overwriting it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_r <= 1'b0;
            buf_tag_r   <= '0;
        end else if ((state_r == ST_RDATA) && (state_s == ST_DONE)) begin
            buf_valid_r <= 1'b1;
            buf_tag_r   <= addr_r[ADDR_WIDTH-1:OFF_BITS];
        end else if (state_r == ST_AR) begin
            buf_valid_r <= 1'b0;
        end
    end
`endif

    // Next-state, beat counter and error detection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        err_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (io.c_strobe_i) begin
                    addr_s = aligned_s;
`ifdef ICACHE_LINE_FILL_LINEBUF_EN
                    if (hit_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_AR;
                    end
`else
                    state_s = ST_AR;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AR: begin
                if (io.bus_arready_i) begin
                    state_s = ST_RDATA;
                end else begin
                    state_s = ST_AR;
                end
            end
            ST_RDATA: begin
                // Completion follows the counter; rlast only feeds the error flag.
                if (io.bus_rvalid_i) begin
                    if (cnt_r == LAST_CNT) begin
                        cnt_s   = '0;
                        state_s = ST_DONE;
                        if (!io.bus_rlast_i) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = err_r;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                        if (io.bus_rlast_i) begin
                            err_s = 1'b1;
                        end else begin
                            err_s = err_r;
                        end
                    end
                end else begin
                    state_s = ST_RDATA;
                end
            end
            ST_DONE: begin
                if (io.c_strobe_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (io.c_strobe_i) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State registers; handshake outputs are decoded from the next state so they leave flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            addr_r    <= '0;
            err_r     <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            c_ready_r <= 1'b0;
            arlen_r   <= 8'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            addr_r    <= addr_s;
            err_r     <= err_s;
            arvalid_r <= (state_s == ST_AR);
            rready_r  <= (state_s == ST_RDATA);
            c_ready_r <= (state_s == ST_DONE);
            arlen_r   <= (state_s == ST_AR) ? ARLEN : 8'd0;
        end
    end

    line_assembler #(
        .BUS_WIDTH (BUS_WIDTH),
        .BEATS     (BEATS),
        .CNT_W     (CNT_W)
    ) u_line_assembler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .we     (beat_we_s),
        .idx    (cnt_r),
        .wdata  (io.bus_rdata_i),
        .line   (line_s)
    );

    assign io.c_ready_o     = c_ready_r;
    assign io.c_data_o      = line_s;
    assign io.bus_arvalid_o = arvalid_r;
    assign io.bus_araddr_o  = addr_r;
    assign io.bus_arlen_o   = arlen_r;
    assign io.bus_rready_o  = rready_r;
    assign io.fill_err_o    = err_r;

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed bench for icache_line_fill with a simple burst-memory responder.
module tb_icache_line_fill;
    import icache_fill_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_line_fill_if #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(32)) bus_if ();

    icache_line_fill #(.ADDR_WIDTH(32), .LINE_SIZE(256), .BUS_WIDTH(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io     (bus_if.master)
    );

    localparam logic [255:0] LINE_A = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
    localparam logic [255:0] LINE_B = 256'hC0DE0000_C0DE0001_C0DE0002_C0DE0003_C0DE0004_C0DE0005_C0DE0006_C0DE0007;
    localparam logic [255:0] LINE_C = 256'hA0000000_A0000001_A0000002_A0000003_A0000004_A0000005_A0000006_A0000007;

    int n_checks = 0;
    int n_errors = 0;

    // responder configuration and state
    int          ar_delay = 0;
    bit          gap_en   = 1'b0;
    int          rlast_at = 7;
    int          ar_wait_cnt = 0;
    int          beat_idx = 8;
    bit          gap_phase = 1'b0;
    int          ar_hs_cnt = 0;
    logic [31:0] beat_words [8];

    // fill results
    int          fill_lat;
    int          fill_arv;
    bit          fill_unstable;
    logic [31:0] fill_araddr;
    logic [7:0]  fill_arlen;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [255:0] line);
        for (int k = 0; k < 8; k++) begin
            beat_words[k] = line[255-32*k -: 32];
        end
    endtask

    // Bus memory model: drives inputs at the falling edge for the next rising edge.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_if.bus_arready_i = 1'b0;
            bus_if.bus_rvalid_i  = 1'b0;
            bus_if.bus_rdata_i   = 32'h0;
            bus_if.bus_rlast_i   = 1'b0;
            ar_wait_cnt = 0;
            beat_idx    = 8;
            gap_phase   = 1'b0;
        end else begin
            bus_if.bus_arready_i = 1'b0;
            if (bus_if.bus_arvalid_o) begin
                if (ar_wait_cnt >= ar_delay) begin
                    bus_if.bus_arready_i = 1'b1;
                    beat_idx  = 0;
                    gap_phase = 1'b0;
                end else begin
                    ar_wait_cnt++;
                end
            end else begin
                ar_wait_cnt = 0;
            end
            bus_if.bus_rvalid_i = 1'b0;
            bus_if.bus_rlast_i  = 1'b0;
            bus_if.bus_rdata_i  = 32'h0;
            if (bus_if.bus_rready_o && beat_idx < 8) begin
                if (gap_en && gap_phase) begin
                    gap_phase = 1'b0;
                end else begin
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i  = beat_words[beat_idx];
                    bus_if.bus_rlast_i  = (beat_idx == rlast_at);
                    beat_idx++;
                    gap_phase = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bus_if.bus_arvalid_o && bus_if.bus_arready_i) ar_hs_cnt++;
    end

    // Raise a request in cycle 0 and run until c_ready_o; strobe is left high.
    task automatic do_fill(input string tag, input logic [31:0] addr);
        fill_lat      = -1;
        fill_arv      = 0;
        fill_unstable = 1'b0;
        fill_araddr   = 32'h0;
        fill_arlen    = 8'h0;
        tick();
        bus_if.c_strobe_i = 1'b1;
        bus_if.c_addr_i   = addr;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (bus_if.bus_arvalid_o) begin
                if (fill_arv == 0) begin
                    fill_araddr = bus_if.bus_araddr_o;
                    fill_arlen  = bus_if.bus_arlen_o;
                end else if (bus_if.bus_araddr_o !== fill_araddr || bus_if.bus_arlen_o !== fill_arlen) begin
                    fill_unstable = 1'b1;
                end
                fill_arv++;
            end
            if (bus_if.c_ready_o) begin
                fill_lat = n;
                break;
            end
        end
        if (fill_lat < 0) check_val({tag, "_timeout"}, 256'd0, 256'd1);
    endtask

    task automatic end_fill(input string tag);
        bus_if.c_strobe_i = 1'b0;
        tick();
        check_val({tag, "_ready_pulse"}, 256'(bus_if.c_ready_o), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        bus_if.c_strobe_i = 1'b0;
        bus_if.c_addr_i   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready",   256'(bus_if.c_ready_o),     256'd0);
        check_val("rst_arvalid", 256'(bus_if.bus_arvalid_o), 256'd0);
        check_val("rst_rready",  256'(bus_if.bus_rready_o),  256'd0);
        check_val("rst_data",    bus_if.c_data_o,            256'd0);
        check_val("rst_err",     256'(bus_if.fill_err_o),    256'd0);
        check_val("rst_araddr",  256'(bus_if.bus_araddr_o),  256'd0);
        check_val("rst_arlen",   256'(bus_if.bus_arlen_o),   256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: baseline fill, zero wait
        load_words(LINE_A);
        hs0 = ar_hs_cnt;
        do_fill("t1", 32'h8000_0044);
        check_val("t1_lat",    256'(fill_lat),    256'd10);
        check_val("t1_arv",    256'(fill_arv),    256'd1);
        check_val("t1_araddr", 256'(fill_araddr), 256'h8000_0040);
        check_val("t1_arlen",  256'(fill_arlen),  256'd7);
        check_val("t1_data",   bus_if.c_data_o,   LINE_A);
        check_val("t1_word0",  256'(bus_if.c_data_o[255:224]), 256'h1111_1111);
        check_val("t1_word7",  256'(bus_if.c_data_o[31:0]),    256'h8888_8888);
        check_val("t1_err",    256'(bus_if.fill_err_o), 256'd0);
        end_fill("t1");
        check_val("t1_hold",   bus_if.c_data_o, LINE_A);
        check_val("t1_hs",     256'(ar_hs_cnt - hs0), 256'd1);

        // 2: arready delayed 3 cycles, beats on every other cycle
        ar_delay = 3;
        gap_en   = 1'b1;
        do_fill("t2", 32'h8000_0044);
        check_val("t2_arv",      256'(fill_arv),      256'd4);
        check_val("t2_stable",   256'(fill_unstable), 256'd0);
        check_val("t2_araddr",   256'(fill_araddr),   256'h8000_0040);
        check_val("t2_lat",      256'(fill_lat),      256'd20);
        check_val("t2_data",     bus_if.c_data_o,     LINE_A);
        end_fill("t2");
        ar_delay = 0;
        gap_en   = 1'b0;

        // 3: strobe lingers 4 cycles after c_ready_o
        hs0 = ar_hs_cnt;
        do_fill("t3", 32'h8000_0044);
        tick();
        check_val("t3_wait",  256'(dut.state_r),      256'(ST_WAIT));
        check_val("t3_ready", 256'(bus_if.c_ready_o), 256'd0);
        fill_arv = 0;
        repeat (3) begin
            tick();
            if (bus_if.bus_arvalid_o) fill_arv++;
        end
        check_val("t3_no_ar", 256'(fill_arv), 256'd0);
        bus_if.c_strobe_i = 1'b0;
        tick();
        check_val("t3_idle",  256'(dut.state_r), 256'(ST_IDLE));
        check_val("t3_hs",    256'(ar_hs_cnt - hs0), 256'd1);

        // 4: early rlast on beat 5 sets the sticky error; fill still ends on beat 7
        rlast_at = 5;
        do_fill("t4", 32'h8000_0044);
        check_val("t4_lat",  256'(fill_lat), 256'd10);
        check_val("t4_err",  256'(bus_if.fill_err_o), 256'd1);
        check_val("t4_data", bus_if.c_data_o, LINE_A);
        end_fill("t4");
        rlast_at = 7;
        load_words(LINE_B);
        do_fill("t4b", 32'h8000_0024);
        check_val("t4b_data",   bus_if.c_data_o, LINE_B);
        check_val("t4b_araddr", 256'(fill_araddr), 256'h8000_0020);
        check_val("t4b_err",    256'(bus_if.fill_err_o), 256'd1);
        end_fill("t4b");

        // 5: reset after beat 3, then a fresh fill
        load_words(LINE_C);
        tick();
        bus_if.c_strobe_i = 1'b1;
        bus_if.c_addr_i   = 32'h8000_0080;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_ready",   256'(bus_if.c_ready_o),     256'd0);
        check_val("t5_arvalid", 256'(bus_if.bus_arvalid_o), 256'd0);
        check_val("t5_rready",  256'(bus_if.bus_rready_o),  256'd0);
        check_val("t5_data",    bus_if.c_data_o,            256'd0);
        check_val("t5_err",     256'(bus_if.fill_err_o),    256'd0);
        check_val("t5_araddr",  256'(bus_if.bus_araddr_o),  256'd0);
        bus_if.c_strobe_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_fill("t5b", 32'h8000_0100);
        check_val("t5b_lat",    256'(fill_lat),    256'd10);
        check_val("t5b_araddr", 256'(fill_araddr), 256'h8000_0100);
        check_val("t5b_data",   bus_if.c_data_o,   LINE_C);
        check_val("t5b_err",    256'(bus_if.fill_err_o), 256'd0);
        end_fill("t5b");

        // 6: same-line re-request, then a different line
        load_words(LINE_A);
        do_fill("t6a", 32'h8000_0040);
        check_val("t6a_lat", 256'(fill_lat), 256'd10);
        end_fill("t6a");
        load_words(LINE_B);
        hs0 = ar_hs_cnt;
        do_fill("t6b", 32'h8000_005C);
`ifdef ICACHE_LINE_FILL_LINEBUF_EN
        check_val("t6b_lat",  256'(fill_lat), 256'd1);
        check_val("t6b_arv",  256'(fill_arv), 256'd0);
        check_val("t6b_data", bus_if.c_data_o, LINE_A);
        check_val("t6b_hs",   256'(ar_hs_cnt - hs0), 256'd0);
`else
        check_val("t6b_lat",  256'(fill_lat), 256'd10);
        check_val("t6b_data", bus_if.c_data_o, LINE_B);
        check_val("t6b_hs",   256'(ar_hs_cnt - hs0), 256'd1);
`endif
        end_fill("t6b");
        load_words(LINE_C);
        hs0 = ar_hs_cnt;
        do_fill("t6c", 32'h8000_0060);
        check_val("t6c_lat",    256'(fill_lat), 256'd10);
        check_val("t6c_araddr", 256'(fill_araddr), 256'h8000_0060);
        check_val("t6c_data",   bus_if.c_data_o, LINE_C);
        check_val("t6c_hs",     256'(ar_hs_cnt - hs0), 256'd1);
        end_fill("t6c");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
